mac_accum: RTL and testbench

Frame-based signed multiply-accumulate stage that sits directly upstream of `rescale`. It accepts streaming W-bit operand pairs and accumulates their full-precision products over one frame. It then saturates the sum to a 2W-bit word and presents it on a valid/ready output whose `out_data` feeds `rescale.din`. Guard bits inside the accumulator keep a full frame of worst-case products from overflowing before the final saturation.

---
 rtl/mac_accum.sv | 111 +++++++++++
 tb/tb_mac_accum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// Frame-based signed multiply-accumulate stage with guard-bit accumulator,
// final saturation to 2W bits and a valid/ready result port.
module mac_accum #(
    parameter int W   = 16,
    parameter int LEN = 64,
    parameter int GW  = $clog2(LEN) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*W-1:0]             out_data,
    output logic                       out_sat,
    output logic [$clog2(LEN+1)-1:0]   out_count
);

    localparam int AW = 2 * W + GW;
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {RUN, FLUSH, SAT, OUT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   frame_end;
    logic                   handshake;
    logic signed [2*W-1:0]  a_ext;
    logic signed [2*W-1:0]  b_ext;
    logic signed [2*W-1:0]  prod;
    logic                   p_valid;
    logic signed [AW-1:0]   acc;
    logic [CW-1:0]          cnt;
    logic [2*W-1:0]         sat_data;
    logic                   sat_flag;

    always_comb begin
        accept    = in_valid && in_ready;
        frame_end = accept && (in_last || (cnt == CW'(LEN - 1)));
        handshake = out_valid && out_ready;
        a_ext     = {{W{in_a[W-1]}}, in_a};
        b_ext     = {{W{in_b[W-1]}}, in_b};
    end

    // Value fits in 2W bits iff all bits above bit 2W-2 agree with the sign.
    always_comb begin
        sat_data = acc[2*W-1:0];
        sat_flag = 1'b0;
        if (!((&acc[AW-1:2*W-1]) || !(|acc[AW-1:2*W-1]))) begin
            sat_flag = 1'b1;
            sat_data = acc[AW-1] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            RUN: begin
                in_ready = rst_n;
                if (frame_end) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = SAT;
            SAT:     state_nxt = OUT;
            OUT:     if (handshake) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod      <= '0;
            p_valid   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                prod <= a_ext * b_ext;
                cnt  <= cnt + CW'(1);
            end
            if (p_valid) acc <= acc + {{GW{prod[2*W-1]}}, prod};
            if (state == SAT) begin
                out_data  <= sat_data;
                out_sat   <= sat_flag;
                out_count <= cnt;
                out_valid <= 1'b1;
            end
            if (state == OUT && handshake) begin
                out_valid <= 1'b0;
                acc       <= '0;
                cnt       <= '0;
                p_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Directed self-checking bench for mac_accum (W=16, LEN=4).
module tb_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_sat;
    logic [2:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    mac_accum #(.W(16), .LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic l);
        in_valid = v; in_a = a; in_b = b; in_last = l;
        tick();
    endtask

    // Called just after the frame-ending edge k, with out_ready=1.
    task automatic expect_result(input string tag, input logic [31:0] d, input logic s, input logic [2:0] c);
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, "_valid_k"}, out_valid, 1'b0);
        chk({tag, "_ready_k"}, in_ready, 1'b0);
        tick();
        chk({tag, "_valid_k1"}, out_valid, 1'b0);
        tick();
        chk({tag, "_valid_k2"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_sat"}, out_sat, s);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_ready_k2"}, in_ready, 1'b0);
        tick();
        chk({tag, "_valid_after_hs"}, out_valid, 1'b0);
        chk({tag, "_ready_after_hs"}, in_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_ready_low", in_ready, 1'b0);
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_sat", out_sat, 1'b0);
        chk("rst_count", out_count, 3'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", in_ready, 1'b1);

        // Full frame ended by the LEN limit: 5+12+21+32 = 70
        drive(1, 16'd1, 16'd5, 0);
        drive(1, 16'd2, 16'd6, 0);
        drive(1, 16'd3, 16'd7, 0);
        drive(1, 16'd4, 16'd8, 0);
        expect_result("full", 32'd70, 1'b0, 3'd4);

        // Early end: -21 + -10 = -31
        drive(1, 16'hFFFD, 16'd7, 0);
        drive(1, 16'd2, 16'hFFFB, 1);
        expect_result("early", 32'hFFFFFFE1, 1'b0, 3'd2);

        // Single most-negative squared pair: 2^30, no clipping
        drive(1, 16'h8000, 16'h8000, 1);
        expect_result("single_min", 32'h40000000, 1'b0, 3'd1);

        // Positive saturation: 4 * 2^30 = 2^32
        repeat (4) drive(1, 16'h8000, 16'h8000, 0);
        expect_result("sat_pos", 32'h7FFFFFFF, 1'b1, 3'd4);

        // Negative saturation: 4 * -1073709056 = -4294836224
        repeat (4) drive(1, 16'h8000, 16'h7FFF, 0);
        expect_result("sat_neg", 32'h80000000, 1'b1, 3'd4);

        // Backpressure with junk on the input
        drive(1, 16'd1, 16'd5, 0);
        drive(1, 16'd2, 16'd6, 0);
        drive(1, 16'd3, 16'd7, 0);
        drive(1, 16'd4, 16'd8, 0);
        out_ready = 1'b0;
        in_a = 16'h1234; in_b = 16'h5678; in_last = 1'b1;
        tick();
        tick();
        chk("bp_valid", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_a = 16'(i * 97 + 3);
            tick();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, 32'd70);
            chk("bp_hold_count", out_count, 3'd4);
            chk("bp_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", out_valid, 1'b0);
        chk("bp_hs_ready", in_ready, 1'b1);
        // in_last coinciding with the LEN limit ends the frame once
        drive(1, 16'd1, 16'd1, 0);
        drive(1, 16'd1, 16'd1, 0);
        drive(1, 16'd1, 16'd1, 0);
        drive(1, 16'd1, 16'd1, 1);
        expect_result("after_bp", 32'd4, 1'b0, 3'd4);
        drive(1, 16'd3, 16'd3, 1);
        expect_result("post_double_end", 32'd9, 1'b0, 3'd1);

        // Input bubbles 1,0,0,1,0,1,1
        drive(1, 16'd1, 16'd5, 0);
        drive(0, 16'd99, 16'd99, 1);
        drive(0, 16'd77, 16'd55, 1);
        drive(1, 16'd2, 16'd6, 0);
        drive(0, 16'd11, 16'd22, 1);
        drive(1, 16'd3, 16'd7, 0);
        drive(1, 16'd4, 16'd8, 0);
        expect_result("bubbles", 32'd70, 1'b0, 3'd4);

        // Reset mid-frame discards the partial frame
        drive(1, 16'd100, 16'd100, 0);
        drive(1, 16'd100, 16'd100, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_low", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_valid", out_valid, 1'b0);
        end
        drive(1, 16'd1, 16'd5, 0);
        drive(1, 16'd2, 16'd6, 0);
        drive(1, 16'd3, 16'd7, 0);
        drive(1, 16'd4, 16'd8, 0);
        expect_result("after_midrst", 32'd70, 1'b0, 3'd4);

        // Reset while holding a result
        out_ready = 1'b0;
        drive(1, 16'd7, 16'd7, 1);
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        tick();
        chk("outrst_valid_before", out_valid, 1'b1);
        chk("outrst_data_before", out_data, 32'd49);
        rst_n = 1'b0;
        tick();
        chk("outrst_valid_cleared", out_valid, 1'b0);
        chk("outrst_data_cleared", out_data, 32'h0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("outrst_ready", in_ready, 1'b1);
        drive(1, 16'hFFFF, 16'd6, 0);
        drive(1, 16'd2, 16'd2, 1);
        expect_result("after_outrst", 32'hFFFFFFFE, 1'b0, 3'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
